// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with first/last framing and a
// running mod-3 remainder of the bits sent so far (reference for bit-serial detectors).
module serial_word_tx #(
  parameter int WIDTH = 16,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic [1:0]       rem3,
  output logic             word_div3,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshake: a word is taken at a posedge where load_valid && load_ready are
  // both 1; load_valid while load_ready=0 is dropped and never stalls anything.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       acc_q, acc_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic       last_bit;
  logic       accept;
  logic [1:0] bit_add;
  logic [2:0] rem_sum;
  logic [1:0] rem_now;

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign accept   = load_valid && load_ready;

  // Odd bit positions carry weight 2 because 2^i mod 3 alternates 1,2,1,2...
  always_comb begin
    bit_add = 2'd0;
    if (shreg_q[0]) begin
      bit_add = cnt_q[0] ? 2'd2 : 2'd1;
    end
    rem_sum = {1'b0, acc_q} + {1'b0, bit_add};
    rem_now = (rem_sum >= 3'd3) ? 2'(rem_sum - 3'd3) : rem_sum[1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        acc_d = 2'd0;
        if (accept) begin
          state_d = ST_SHIFT;
          shreg_d = load_data;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          acc_d = 2'd0;
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GW'((GAP == 0) ? 0 : GAP - 1);
          end else if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = load_data;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          acc_d   = rem_now;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs, all derived from registered state
  always_comb begin
    load_ready = (state_q == ST_IDLE) || (last_bit && (GAP == 0));
    ser_valid  = (state_q == ST_SHIFT);
    ser_out    = ser_valid && shreg_q[0];
    ser_first  = ser_valid && (cnt_q == '0);
    ser_last   = last_bit;
    rem3       = ser_valid ? rem_now : 2'd0;
    word_div3  = last_bit && (rem_now == 2'd0);
    busy       = (state_q != ST_IDLE);
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: one back-to-back instance (GAP=0) and one
// with a 3-cycle inter-word gap.
module tb_serial_word_tx;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         lv0, lr0, so0, sv0, sf0, sl0, wd0, busy0;
  logic [W-1:0] ld0;
  logic [1:0]   rem0, st0;
  logic         lv3, lr3, so3, sv3, sf3, sl3, wd3, busy3;
  logic [W-1:0] ld3;
  logic [1:0]   rem3_3, st3;

  int n_tests = 0;
  int n_fail  = 0;

  serial_word_tx #(.WIDTH(W), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .load_valid(lv0), .load_ready(lr0), .load_data(ld0),
    .ser_out(so0), .ser_valid(sv0), .ser_first(sf0), .ser_last(sl0), .rem3(rem0),
    .word_div3(wd0), .busy(busy0), .state_dbg(st0)
  );

  serial_word_tx #(.WIDTH(W), .GAP(3)) dut3 (
    .clk(clk), .reset(reset), .load_valid(lv3), .load_ready(lr3), .load_data(ld3),
    .ser_out(so3), .ser_valid(sv3), .ser_first(sf3), .ser_last(sl3), .rem3(rem3_3),
    .word_div3(wd3), .busy(busy3), .state_dbg(st3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_rem(input logic [W-1:0] w, input int i);
    logic [W-1:0] part;
    part = w & W'((32'd1 << (i + 1)) - 32'd1);
    return 2'(part % 3);
  endfunction

  // Per-bit checks on dut0 for bit i of word w
  task automatic check_bit0(input string tag, input logic [W-1:0] w, input int i);
    check({tag, "_valid"}, sv0, 1'b1);
    check({tag, "_bit"},   so0, w[i]);
    check({tag, "_first"}, sf0, (i == 0));
    check({tag, "_last"},  sl0, (i == W - 1));
    check({tag, "_rem3"},  rem0, exp_rem(w, i));
    check({tag, "_div3"},  wd0, (i == W - 1) && (w % 3 == 0));
    check({tag, "_busy"},  busy0, 1'b1);
    check({tag, "_ready"}, lr0, (i == W - 1));
  endtask

  // Send one word on dut0; optionally pulse a rogue load or assert reset mid-word
  task automatic send_word0(input string tag, input logic [W-1:0] w,
                            input int pulse_at, input int rst_at);
    @(posedge clk); #1;
    lv0 = 1'b1;
    ld0 = w;
    @(negedge clk);
    check({tag, "_idle_ready"}, lr0, 1'b1);
    @(posedge clk); #1;
    lv0 = 1'b0;
    ld0 = ~w;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check_bit0(tag, w, i);
      lv0 = 1'b0;
      if (i == pulse_at) begin
        lv0 = 1'b1;
        ld0 = 16'hFFFF;
      end
      if (i == rst_at) begin
        reset = 1'b0;
        @(negedge clk);
        check({tag, "_rst_valid"}, sv0, 1'b0);
        check({tag, "_rst_rem3"},  rem0, 2'd0);
        check({tag, "_rst_ready"}, lr0, 1'b1);
        check({tag, "_rst_busy"},  busy0, 1'b0);
        check({tag, "_rst_state"}, st0, 2'd0);
        reset = 1'b1;
        return;
      end
    end
    @(negedge clk);
    check({tag, "_after_valid"}, sv0, 1'b0);
    check({tag, "_after_busy"},  busy0, 1'b0);
    check({tag, "_after_rem3"},  rem0, 2'd0);
    check({tag, "_after_div3"},  wd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    lv0 = 1'b0; ld0 = '0;
    lv3 = 1'b0; ld3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", lr0, 1'b1);
    check("reset_valid", sv0, 1'b0);
    check("reset_busy",  busy0, 1'b0);
    check("reset_rem3",  rem0, 2'd0);
    check("reset_out",   so0, 1'b0);
    check("reset_state", st0, 2'd0);
    check("reset_ready3", lr3, 1'b1);
    reset = 1'b1;

    // Pattern word: bits 0,0,0,1,1,1,0,1,0,0,0,1,1,1,0,0; 0x38B8 = 14520 = 3*4840
    send_word0("t1", 16'b0011100010111000, -1, -1);

    // Single LSB set: rem3 stays 1 for all bits
    send_word0("t2", 16'h0001, -1, -1);

    // Back-to-back FFFF then 0000 with load_valid held
    @(posedge clk); #1;
    lv0 = 1'b1;
    ld0 = 16'hFFFF;
    @(posedge clk); #1;
    ld0 = 16'h0000;
    for (int c = 1; c <= 2 * W; c++) begin
      @(negedge clk);
      check_bit0("t3", (c <= W) ? 16'hFFFF : 16'h0000, (c - 1) % W);
      if (c == W) check("t3_div3_16", wd0, 1'b1);
      if (c == W + 1) check("t3_acc_clr", rem0, 2'd0);
      if (c == 2 * W) check("t3_div3_32", wd0, 1'b1);
      if (c == W + 1) lv0 = 1'b0;
    end
    @(negedge clk);
    check("t3_end_valid", sv0, 1'b0);

    // GAP=3 instance: two words queued back to back
    @(posedge clk); #1;
    lv3 = 1'b1;
    ld3 = 16'h00F0;
    @(posedge clk); #1;
    ld3 = 16'h0003;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("t4_valid", sv3, 1'b1);
      check("t4_bit",   so3, ((16'h00F0 >> i) & 16'h1) != 0);
    end
    check("t4_last",  sl3, 1'b1);
    check("t4_div3",  wd3, 1'b1);
    check("t4_ready_last", lr3, 1'b0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      check("t4_gap_valid", sv3, 1'b0);
      check("t4_gap_ready", lr3, 1'b0);
      check("t4_gap_busy",  busy3, 1'b1);
    end
    @(negedge clk);
    check("t4_idle_valid", sv3, 1'b0);
    check("t4_idle_ready", lr3, 1'b1);
    check("t4_idle_busy",  busy3, 1'b0);
    @(posedge clk); #1;
    lv3 = 1'b0;
    @(negedge clk);
    check("t4_w2_first", sf3, 1'b1);
    check("t4_w2_bit0",  so3, 1'b1);
    check("t4_w2_rem3",  rem3_3, 2'd1);
    @(negedge clk);
    check("t4_w2_rem3_b1", rem3_3, 2'd0);

    // Reset during bit 7, then a fresh word starts from bit 0
    send_word0("t5", 16'hA5C3, -1, 7);
    send_word0("t5b", 16'h0003, -1, -1);

    // Rogue load pulse mid-word is ignored
    send_word0("t6", 16'h0005, 5, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
